sigmoid: RTL and testbench
==========================

Name: sigmoid

Overview:
Forward activation unit: computes a = 1/(1+e^-z) for one signed Q5.10 operand per transfer, using a piecewise-linear (PLAN) approximation built only from shifts and adds.
Three-stage pipeline with valid/ready handshakes on input and output.
Sits between the weighted-sum accumulator (z) and the layer output register.
Its output a is the same Q5.10 value the backward-path derivative unit consumes.

Parameters:
W, 16, data width; the Q5.10 constants below are fixed for W=16 (other values unsupported).
FRAC, 10, fraction bits (1.0 = 1024).

Ports:
clk  input  1  clock, all logic on rising edge
res  input  1  synchronous reset, active-low (res==0 resets on the clk edge)
z  input  16  signed Q5.10 pre-activation
in_valid  input  1  z valid
in_ready  output  1  unit accepts z this cycle
a  output  16  signed Q5.10 activation, range 0..1024
out_valid  output  1  a valid
out_ready  input  1  downstream accepts a this cycle

Behaviour:
- Reset (res==0 at clk edge):
  - all stage valid bits = 0; a = 0; out_valid = 0.
  - in_ready = 1 in the cycle after reset.
  - Reset mid-operation discards all in-flight data; no output is produced for it.
- Handshakes:
  - input transfer when in_valid & in_ready.
  - output transfer when out_valid & out_ready.
  - a and out_valid hold stable while out_valid & !out_ready.
- Stall:
  - stall = out_valid & !out_ready; in_ready = !stall (combinational).
  - All three stages advance together when !stall and hold when stall.
  - Bubbles are not compressed during a stall.
- Latency: 3 cycles from input transfer to out_valid. Throughput: 1 per clock when out_ready = 1.
- Stage 1 (capture):
  - s1_sign = z[15]; s1_abs = |z|.
  - z = -32768 saturates to s1_abs = 32767.
  - s1_valid = in_valid.
- Stage 2 (segment select on s1_abs, unsigned compare; all shifts are logical right shifts, truncating):
  - s1_abs >= 5120 (|z| >= 5.0): y = 1024.
  - 2432 <= s1_abs < 5120: y = (s1_abs>>5) + 864.
  - 1024 <= s1_abs < 2432: y = (s1_abs>>3) + 640.
  - s1_abs < 1024: y = (s1_abs>>2) + 512.
  - Sign and valid pipelined alongside y.
  - y is always in 512..1024; no overflow is possible in 11 bits.
- Stage 3 (symmetry): a = s2_sign ? (1024 - y) : y; out_valid = s2_valid.
- Result ranges:
  - a is never negative and never exceeds 1024.
  - z = 0 gives exactly 512.
  - Negative z gives a in 0..512.
- Simultaneous events:
  - Output transfer and input transfer in the same cycle are legal; the pipeline shifts by one.
  - in_valid while in_ready = 0: no transfer, z is ignored, and upstream must hold it.

Test Plan:
- Reset and idle: res = 0 for 2 clocks, then res = 1 with in_valid = 0 -> a = 0, out_valid = 0, in_ready = 1.
- Segment points, out_ready = 1, one per cycle:
  - z = 0 -> a = 512.
  - z = 512 -> 640.
  - z = 1024 -> 768.
  - z = 2432 -> 940.
  - z = 5119 -> 1023.
  - z = 6000 -> 1024.
  - Each result appears exactly 3 cycles after its input.
- Negative and saturation:
  - z = -1024 -> 256.
  - z = -2432 -> 84.
  - z = -32768 -> 0.
  - z = 32767 -> 1024.
- Back-to-back streaming: 20 random z with in_valid = 1 and out_ready = 1 continuously -> 20 outputs on consecutive cycles, in order, matching the reference model bit-exactly.
- Backpressure:
  - Inputs 0, 1024, -1024, 6000 streamed with out_ready = 0.
  - in_ready falls once out_valid = 1; a holds 512 stable.
  - Release out_ready -> outputs 512, 768, 256, 1024 in order, none lost or duplicated.
- Reset mid-stream: 3 values in flight, assert res = 0 for 1 clock -> out_valid = 0 next cycle; none of the flushed values ever appear at the output.

Source files
------------

// File: rtl/sigmoid.sv
// Piecewise-linear (PLAN) logistic activation, signed Q5.10 in and out.
// Three-stage shift/add pipeline with valid/ready handshakes; all stages stall together.
module sigmoid #(
    parameter int W    = 16,
    parameter int FRAC = 10
) (
    input  logic                clk,
    input  logic                res,
    input  logic signed [W-1:0] z,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [W-1:0] a,
    output logic                out_valid,
    input  logic                out_ready
);

    // Segment breakpoints and offsets in Q5.10 (fixed for W=16, FRAC=10)
    localparam logic [W-1:0] ONE   = W'(1 << FRAC);
    localparam logic [W-1:0] B_SAT = W'(5120);
    localparam logic [W-1:0] B_MID = W'(2432);
    localparam logic [W-1:0] B_LO  = W'(1024);
    localparam logic [W-1:0] K_MID = W'(864);
    localparam logic [W-1:0] K_LO  = W'(640);
    localparam logic [W-1:0] K_CTR = W'(512);

    // Magnitude with the most-negative code clamped so it stays in W-1 bits
    function automatic logic [W-1:0] abs_sat(input logic signed [W-1:0] v);
        logic signed [W-1:0] n;
        n = -v;
        if (v == {1'b1, {(W-1){1'b0}}})
            return {1'b0, {(W-1){1'b1}}};
        else if (v[W-1])
            return n;
        else
            return v;
    endfunction

    function automatic logic [FRAC:0] plan_y(input logic [W-1:0] m);
        logic [W-1:0] t;
        if (m >= B_SAT)
            t = ONE;
        else if (m >= B_MID)
            t = (m >> 5) + K_MID;
        else if (m >= B_LO)
            t = (m >> 3) + K_LO;
        else
            t = (m >> 2) + K_CTR;
        return t[FRAC:0];
    endfunction

    function automatic logic signed [W-1:0] mirror(input logic s, input logic [FRAC:0] y);
        logic [W-1:0] ye;
        ye = W'(y);
        return s ? $signed(ONE - ye) : $signed(ye);
    endfunction

    logic                stall;
    logic                vld_p0, vld_p1, vld_p2;
    logic                sign_p0, sign_p1;
    logic [W-1:0]        abs_p0;
    logic [FRAC:0]       y_p1;
    logic signed [W-1:0] a_p2;

    assign stall     = vld_p2 & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld_p2;
    assign a         = a_p2;

    always_ff @(posedge clk) begin
        if (!res) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            a_p2   <= '0;
        end else if (!stall) begin
            vld_p0 <= in_valid;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            // stage 3: mirror around 0.5 for negative inputs
            a_p2   <= mirror(sign_p1, y_p1);
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            // stage 1: capture sign and saturated magnitude
            sign_p0 <= z[W-1];
            abs_p0  <= abs_sat(z);
            // stage 2: segment select
            sign_p1 <= sign_p0;
            y_p1    <= plan_y(abs_p0);
        end
    end

endmodule

// File: tb/tb_sigmoid.sv
// Randomized and directed bench for sigmoid, scored against an arithmetic
// model of the piecewise-linear curve with latency, hold and ordering checks.
module tb_sigmoid;

    logic               clk = 1'b0;
    logic               res;
    logic signed [15:0] z;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] a;
    logic               out_valid;
    logic               out_ready;

    always #5 clk = ~clk;

    sigmoid #(.W(16), .FRAC(10)) dut (
        .clk(clk),
        .res(res),
        .z(z),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    int               n_assert = 0;
    int               n_fail   = 0;
    int               cyc      = 0;
    int               exp_q[$];
    int               t_q[$];
    bit               chk_lat  = 1'b0;
    bit               prev_stall = 1'b0;
    bit               accepted = 1'b0;
    logic signed [15:0] prev_a;

    function automatic int ref_a(input int zv);
        int m;
        int y;
        m = (zv < 0) ? -zv : zv;
        if (m > 32767) m = 32767;
        if (m >= 5120)      y = 1024;
        else if (m >= 2432) y = m / 32 + 864;
        else if (m >= 1024) y = m / 8 + 640;
        else                y = m / 4 + 512;
        return (zv < 0) ? 1024 - y : y;
    endfunction

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, check outputs of this cycle, score transfers, advance.
    task automatic tick(input logic iv, input logic signed [15:0] zi,
                        input logic ordy, input int expv);
        logic exp_rdy;
        int   e;
        int   t;
        in_valid  = iv;
        z         = zi;
        out_ready = ordy;
        #1;
        exp_rdy = !(out_valid && !ordy);
        check("in_ready", in_ready, exp_rdy);
        if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_a", a, prev_a);
        end
        if (out_valid === 1'b1 && ordy) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                t = t_q.pop_front();
                check("a", a, e);
                if (chk_lat) check("latency", cyc - t, 3);
            end
        end
        accepted = iv && (in_ready === 1'b1);
        if (accepted && res) begin
            exp_q.push_back(expv);
            t_q.push_back(cyc);
        end
        prev_stall = (out_valid === 1'b1) && !ordy;
        prev_a     = a;
        @(posedge clk);
        #1;
        cyc++;
        if (!res) begin
            exp_q.delete();
            t_q.delete();
            prev_stall = 1'b0;
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'sd0, 1'b1, 0);
    endtask

    logic signed [15:0] dz [10] = '{16'sd0, 16'sd512, 16'sd1024, 16'sd2432, 16'sd5119,
                                    16'sd6000, -16'sd1024, -16'sd2432, -16'sd32768, 16'sd32767};
    int                 de [10] = '{512, 640, 768, 940, 1023, 1024, 256, 84, 0, 1024};

    initial begin
        logic signed [15:0] zr;
        int                 guard;

        // Reset and idle
        res = 1'b0; in_valid = 1'b0; z = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        res = 1'b1;
        #1;
        check("rst_a", a, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Segment points, saturation and negatives, one per cycle
        chk_lat = 1'b1;
        for (int i = 0; i < 10; i++) tick(1'b1, dz[i], 1'b1, de[i]);
        drain(5);

        // Back-to-back random stream
        for (int i = 0; i < 20; i++) begin
            zr = 16'($urandom);
            tick(1'b1, zr, 1'b1, ref_a(int'(zr)));
            check("stream_accept", accepted, 1);
        end
        drain(5);

        // Backpressure
        chk_lat = 1'b0;
        tick(1'b1, 16'sd0, 1'b0, 512);
        tick(1'b1, 16'sd1024, 1'b0, 768);
        tick(1'b1, -16'sd1024, 1'b0, 256);
        for (int i = 0; i < 4; i++) tick(1'b1, 16'sd6000, 1'b0, 1024);
        check("bp_in_ready", in_ready, 0);
        check("bp_hold_a", a, 512);
        guard = 0;
        do begin
            tick(1'b1, 16'sd6000, 1'b1, 1024);
            guard++;
        end while (!accepted && guard < 10);
        check("bp_accept", accepted, 1);
        drain(8);

        // Reset with data in flight
        tick(1'b1, 16'sd100, 1'b0, ref_a(100));
        tick(1'b1, -16'sd300, 1'b0, ref_a(-300));
        tick(1'b1, 16'sd2000, 1'b0, ref_a(2000));
        res = 1'b0;
        tick(1'b0, 16'sd0, 1'b0, 0);
        res = 1'b1;
        check("flush_out_valid", out_valid, 0);
        check("flush_a", a, 0);
        drain(6);

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
